// File: rtl/subtractor32_serial_pkg.sv
// Shared types and sizing for the nibble-serial 32-bit subtractor.
// The slice width is fixed by the adder4 slice adder.
package subtractor32_serial_pkg;

  localparam int DATA_W    = 32;
  localparam int SLICE_W   = 4;
  localparam int SLICE_CNT = DATA_W / SLICE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic borrow;
    logic zero;
    logic negative;
    logic overflow;
  } flags_t;

  // Flags of a finished subtraction, from the full result and operand sign bits.
  function automatic flags_t calc_flags(input logic [DATA_W-1:0] diff_full,
                                        input logic              borrow_in,
                                        input logic              a_msb,
                                        input logic              b_msb);
    flags_t f;
    f.borrow   = borrow_in;
    f.zero     = (diff_full == '0);
    f.negative = diff_full[DATA_W-1];
    f.overflow = (a_msb != b_msb) && (diff_full[DATA_W-1] != a_msb);
    return f;
  endfunction

endpackage

// File: rtl/adder4.sv
// 4-bit ripple slice adder with carry in/out.
// Purely combinational; no state, no flow control.
module adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

endmodule

// File: rtl/subtractor32_serial.sv
// Nibble-serial a - b (a + ~b + 1), LSB slice first; result 8 cycles after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module subtractor32_serial
  import subtractor32_serial_pkg::*;
#(
  parameter int NIBBLES = SLICE_CNT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   diff,
  output logic                borrow,
  output logic                zero,
  output logic                negative,
  output logic                overflow
);

  localparam int             K_W    = $clog2(NIBBLES);
  localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);
  localparam int             LOW_W  = DATA_W - SLICE_W;

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_bn;
  logic [DATA_W-1:0]   r_diff;
  logic [K_W-1:0]      r_k;
  logic                r_carry;
  flags_t              r_flags;

  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_bn_sl;
  logic [SLICE_W-1:0]  w_sum;
  logic                w_cout;
  logic                w_last;
  logic [DATA_W-1:0]   w_diff_final;
  flags_t              w_flags_final;

  assign w_a_sl  = r_a[r_k*SLICE_W +: SLICE_W];
  assign w_bn_sl = r_bn[r_k*SLICE_W +: SLICE_W];
  assign w_last  = (r_k == K_LAST);

  adder4 u_slice_add (
    .i_a    (w_a_sl),
    .i_b    (w_bn_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // On the last slice the top nibble is still in flight, so splice it in for the flags.
  assign w_diff_final  = {w_sum, r_diff[LOW_W-1:0]};
  assign w_flags_final = calc_flags(w_diff_final, ~w_cout, r_a[DATA_W-1], ~r_bn[DATA_W-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_bn    <= '0;
      r_diff  <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bn    <= ~b;
            r_carry <= 1'b1;
            r_k     <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_diff[r_k*SLICE_W +: SLICE_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_flags <= w_flags_final;
            r_state <= ST_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_flags <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign diff      = r_diff;
  assign borrow    = r_flags.borrow;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign overflow  = r_flags.overflow;

`ifdef FORMAL
  always_comb begin
    if (out_valid) begin
      assert (r_diff == r_a - ~r_bn);
      assert (borrow == (r_a < ~r_bn));
    end
  end
`endif

endmodule

// File: tb/tb_subtractor32_serial.sv
// Randomised and directed checks of subtractor32_serial against a plain-arithmetic model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_subtractor32_serial;

  localparam int N_STREAM  = 2500;
  localparam int CYC_LIMIT = 60000;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;   // {borrow, zero, negative, overflow}
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        negative;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  subtractor32_serial dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [31:0] d;
    d   = x - y;
    e.d = d;
    e.f = {x < y, d == 32'd0, d[31], (x[31] != y[31]) && (d[31] != x[31])};
    return e;
  endfunction

  function automatic logic [3:0] dut_flags();
    return {borrow, zero, negative, overflow};
  endfunction

  // Presents one pair from a falling edge, waits for the result and checks it.
  // With hold set the result is left pending in DONE.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input string tag,
                       input bit hold);
    int   lat;
    exp_t e;
    e        = model(x, y);
    op_a     = x;
    op_b     = y;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_diff"}, diff, e.d);
    chk({tag, "_flags"}, {28'd0, dut_flags()}, {28'd0, e.f});
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
    end
  endtask

  initial begin
    exp_t        q[$];
    exp_t        e;
    logic [31:0] held_d;
    logic [31:0] pa;
    logic [31:0] pb;
    bit          have;
    int          sent;
    int          got;
    int          cyc;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_flags", {28'd0, dut_flags()}, 32'd0);

    // First accept happens on the very first rising edge after release.
    reset_n = 1'b1;
    do_op(32'h0000_0005, 32'h0000_0003, "small_pos", 1'b0);
    do_op(32'h0000_0003, 32'h0000_0005, "small_neg", 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, "sgn_ovf", 1'b0);
    do_op(32'h1234_5678, 32'h1234_5678, "equal", 1'b0);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, "ovf_pos", 1'b0);
    do_op(32'h0000_0000, 32'h0000_0000, "zeros", 1'b0);

    // Stall in DONE while new operands are offered; they must be ignored.
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, "stall", 1'b1);
    held_d = diff;
    for (int i = 0; i < 5; i++) begin
      op_a     = $urandom;
      op_b     = $urandom;
      in_valid = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("stall_hold_diff", diff, held_d);
      chk("stall_hold_ctrl", {30'd0, out_valid, in_ready}, 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release", {30'd0, out_valid, in_ready}, 32'b01);
    do_op(32'h0000_1000, 32'h0000_0001, "after_stall", 1'b0);

    // Abort mid-operation at slice 4.
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'h0000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", {30'd0, out_valid, in_ready}, 32'b00);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_diff", diff, 32'd0);
    chk("abort_flags", {28'd0, dut_flags()}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(32'h0000_0010, 32'h0000_0020, "post_abort", 1'b0);

    // Random stream with input gaps and output stalls, results checked in order.
    sent = 0;
    got  = 0;
    cyc  = 0;
    have = 1'b0;
    pa   = 32'd0;
    pb   = 32'd0;
    while (got < N_STREAM && cyc < CYC_LIMIT) begin
      if (!have && sent < N_STREAM) begin
        pa = $urandom;
        pb = $urandom;
        case ($urandom_range(0, 7))
          0: pb = pa;
          1: pa = 32'h8000_0000;
          2: pb = 32'h8000_0000;
          3: pa = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'd0} | (pa & 32'hF);
          default: ;
        endcase
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(0, 3) != 0);
      op_a      = pa;
      op_b      = pb;
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q.push_back(model(pa, pb));
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", got + 1, sent);
        end else begin
          e = q.pop_front();
          chk("stream_diff", diff, e.d);
          chk("stream_flags", {28'd0, dut_flags()}, {28'd0, e.f});
        end
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_count", got, N_STREAM);
    chk("stream_leftover", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
